// File: rtl/lia_pkg.sv
// Shared definitions for the lock-in amplifier frequency sweep controller.
// Holds the sweep FSM state encoding, the accumulator guard width and a
// helper that turns the averaging exponent into a sample count.
package lia_pkg;

    // Extra accumulator bits so that up to 2^7 samples can be summed
    // without losing the carry.
    localparam int ACC_GUARD = 7;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        ACCUM,
        EVAL,
        DONE
    } sweep_state_t;

    // Number of samples averaged per point for a given exponent (1..128).
    function automatic logic [7:0] avg_count(input logic [2:0] shift);
        return 8'd1 << shift;
    endfunction

endpackage

// File: rtl/lia_mag_averager.sv
// Magnitude averager for one sweep point.
// Sums 2^avg_shift strobed magnitude samples and presents the average.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   clear        - discard the running sum and sample count
//   sample       - accept mag_in this cycle (ignored once the set is full)
//   avg_shift    - averaging exponent
//   mag_in       - lock-in magnitude sample
//   avg          - running sum shifted right by avg_shift
//   sum_done     - high once 2^avg_shift samples have been summed
module lia_mag_averager
    import lia_pkg::*;
#(
    parameter int MAG_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 sample,
    input  logic [2:0]           avg_shift,
    input  logic [MAG_WIDTH-1:0] mag_in,
    output logic [MAG_WIDTH-1:0] avg,
    output logic                 sum_done
);

    localparam int ACC_WIDTH = MAG_WIDTH + ACC_GUARD;

    logic [ACC_WIDTH-1:0] acc;
    logic [7:0]           count;
    logic [ACC_WIDTH-1:0] shifted;

    // Once the set is complete further samples are dropped so the sum
    // cannot be disturbed while the controller moves on to evaluation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            count <= '0;
        end else if (clear) begin
            acc   <= '0;
            count <= '0;
        end else if (sample && !sum_done) begin
            acc   <= acc + {{ACC_GUARD{1'b0}}, mag_in};
            count <= count + 8'd1;
        end
    end

    always_comb begin
        sum_done = (count == avg_count(avg_shift));
        shifted  = acc >> avg_shift;
        avg      = shifted[MAG_WIDTH-1:0];
    end

endmodule

// File: rtl/lia_freq_sweep_ctrl.sv
// Lock-in amplifier reference-frequency sweep controller.
// Steps the reference frequency from f_start to f_stop in f_step increments,
// waits settle_samples magnitude strobes after each change, averages
// 2^avg_shift magnitudes, and tracks the frequency with the largest average.
// After the sweep the reference is parked on the peak frequency.
// Ports:
//   clk, rst_n                - clock, asynchronous active-low reset
//   start, abort              - sweep request pulse, cancel request
//   f_start, f_stop, f_step   - sweep range and increment (Hz)
//   settle_samples, avg_shift - settle discard count, averaging exponent
//   mag_in, mag_valid         - lock-in magnitude and strobe
//   ref_frequency             - frequency driven to the tuning logic
//   busy, done, error         - sweep running, completion pulse, bad-config pulse
//   peak_freq, peak_mag       - best point found so far
//   point_index               - index of the point being measured (saturating)
module lia_freq_sweep_ctrl
    import lia_pkg::*;
#(
    parameter int FREQ_WIDTH   = 32,
    parameter int MAG_WIDTH    = 24,
    parameter int SETTLE_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [FREQ_WIDTH-1:0]   f_start,
    input  logic [FREQ_WIDTH-1:0]   f_stop,
    input  logic [FREQ_WIDTH-1:0]   f_step,
    input  logic [SETTLE_WIDTH-1:0] settle_samples,
    input  logic [2:0]              avg_shift,
    input  logic [MAG_WIDTH-1:0]    mag_in,
    input  logic                    mag_valid,
    output logic [FREQ_WIDTH-1:0]   ref_frequency,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [FREQ_WIDTH-1:0]   peak_freq,
    output logic [MAG_WIDTH-1:0]    peak_mag,
    output logic [15:0]             point_index
);

    sweep_state_t state, next_state;

    logic [FREQ_WIDTH-1:0]   cfg_stop;
    logic [FREQ_WIDTH-1:0]   cfg_step;
    logic [SETTLE_WIDTH-1:0] cfg_settle;
    logic [2:0]              cfg_shift;
    logic [SETTLE_WIDTH-1:0] settle_cnt;

    logic                    cfg_valid;
    logic                    start_ok;
    logic                    start_bad;
    logic [FREQ_WIDTH:0]     next_freq;
    logic                    sweep_end;
    logic                    new_peak;
    logic                    settle_done;
    logic                    avg_clear;
    logic                    avg_sample;
    logic [MAG_WIDTH-1:0]    avg;
    logic                    sum_done;

    lia_mag_averager #(
        .MAG_WIDTH (MAG_WIDTH)
    ) u_averager (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (avg_clear),
        .sample    (avg_sample),
        .avg_shift (cfg_shift),
        .mag_in    (mag_in),
        .avg       (avg),
        .sum_done  (sum_done)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; abort overrides every transition outside IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_ok) next_state = SETTLE;
            SETTLE:  if (settle_done) next_state = ACCUM;
            ACCUM:   if (sum_done) next_state = EVAL;
            EVAL:    next_state = sweep_end ? DONE : SETTLE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (abort && state != IDLE) begin
            next_state = IDLE;
        end
    end

    // Decode of the current state and the datapath decisions it needs.
    // The next frequency is formed one bit wider so a wrap past the top of
    // the frequency range is caught as an end-of-sweep condition.
    always_comb begin
        cfg_valid   = (f_step != '0) && (f_start <= f_stop);
        start_ok    = (state == IDLE) && start && !abort && cfg_valid;
        start_bad   = (state == IDLE) && start && !abort && !cfg_valid;
        next_freq   = {1'b0, ref_frequency} + {1'b0, cfg_step};
        sweep_end   = next_freq[FREQ_WIDTH] || (next_freq[FREQ_WIDTH-1:0] > cfg_stop);
        new_peak    = (avg > peak_mag);
        settle_done = (settle_cnt == cfg_settle);
        avg_clear   = start_ok || (state == EVAL);
        avg_sample  = (state == ACCUM) && mag_valid;
    end

    // Sweep datapath: configuration capture, frequency stepping, peak
    // tracking and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_stop      <= '0;
            cfg_step      <= '0;
            cfg_settle    <= '0;
            cfg_shift     <= '0;
            settle_cnt    <= '0;
            ref_frequency <= '0;
            peak_freq     <= '0;
            peak_mag      <= '0;
            point_index   <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= start_bad;
            if (abort && state != IDLE) begin
                busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_ok) begin
                            cfg_stop      <= f_stop;
                            cfg_step      <= f_step;
                            cfg_settle    <= settle_samples;
                            cfg_shift     <= avg_shift;
                            settle_cnt    <= '0;
                            ref_frequency <= f_start;
                            peak_freq     <= f_start;
                            peak_mag      <= '0;
                            point_index   <= '0;
                            busy          <= 1'b1;
                        end
                    end
                    SETTLE: begin
                        if (mag_valid && !settle_done) begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                    EVAL: begin
                        if (new_peak) begin
                            peak_mag  <= avg;
                            peak_freq <= ref_frequency;
                        end
                        if (!sweep_end) begin
                            ref_frequency <= next_freq[FREQ_WIDTH-1:0];
                            settle_cnt    <= '0;
                            if (point_index != 16'hFFFF) begin
                                point_index <= point_index + 16'd1;
                            end
                        end
                    end
                    DONE: begin
                        ref_frequency <= peak_freq;
                        done          <= 1'b1;
                        busy          <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lia_freq_sweep_ctrl.sv
// Directed self-checking bench for lia_freq_sweep_ctrl.
// A background process strobes mag_valid every third cycle with a magnitude
// chosen from a fixed frequency-to-magnitude table; the main process runs a
// linear sequence of sweeps and checks results against hand-computed values.
module tb_lia_freq_sweep_ctrl;
    import lia_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] f_start;
    logic [31:0] f_stop;
    logic [31:0] f_step;
    logic [15:0] settle_samples;
    logic [2:0]  avg_shift;
    logic [23:0] mag_in;
    logic        mag_valid;
    logic [31:0] ref_frequency;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] peak_freq;
    logic [23:0] peak_mag;
    logic [15:0] point_index;

    int checks = 0;
    int errors = 0;
    logic flat_mag = 1'b0;
    logic found;

    lia_freq_sweep_ctrl #(
        .FREQ_WIDTH   (32),
        .MAG_WIDTH    (24),
        .SETTLE_WIDTH (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .f_start        (f_start),
        .f_stop         (f_stop),
        .f_step         (f_step),
        .settle_samples (settle_samples),
        .avg_shift      (avg_shift),
        .mag_in         (mag_in),
        .mag_valid      (mag_valid),
        .ref_frequency  (ref_frequency),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .peak_freq      (peak_freq),
        .peak_mag       (peak_mag),
        .point_index    (point_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Magnitude response seen by the bench: a peak at 1200 Hz.
    function automatic logic [23:0] magFor(input logic [31:0] f, input logic flat);
        if (flat) return 24'd33;
        case (f)
            32'd1000: return 24'd10;
            32'd1100: return 24'd20;
            32'd1200: return 24'd50;
            32'd1300: return 24'd30;
            32'd1400: return 24'd5;
            default:  return 24'd7;
        endcase
    endfunction

    // Magnitude strobe every third cycle, driven just after the rising edge.
    initial begin
        mag_valid = 1'b0;
        mag_in    = '0;
        forever begin
            for (int p = 0; p < 3; p++) begin
                @(posedge clk);
                #1;
                mag_valid = (p == 2);
                mag_in    = magFor(ref_frequency, flat_mag);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] fs, input logic [31:0] fe,
                                 input logic [31:0] st, input logic [15:0] settle,
                                 input logic [2:0] shift);
        f_start        = fs;
        f_stop         = fe;
        f_step         = st;
        settle_samples = settle;
        avg_shift      = shift;
        start          = 1'b1;
        @(posedge clk);
        #1;
        start          = 1'b0;
    endtask

    task automatic waitDone(input int budget, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        start          = 1'b0;
        abort          = 1'b0;
        f_start        = '0;
        f_stop         = '0;
        f_step         = '0;
        settle_samples = '0;
        avg_shift      = '0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_ref", ref_frequency, 0);
        checkOutput("rst_peak_freq", peak_freq, 0);
        checkOutput("rst_peak_mag", peak_mag, 0);
        checkOutput("rst_point_index", point_index, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic sweep with a peak at 1200 Hz.
        $display("[TB] sweep 1000..1400 step 100");
        applyStimulus(32'd1000, 32'd1400, 32'd100, 16'd4, 3'd2);
        checkOutput("start_busy", busy, 1);
        checkOutput("start_ref", ref_frequency, 1000);
        checkOutput("start_index", point_index, 0);
        checkOutput("start_peak_mag", peak_mag, 0);
        checkOutput("start_peak_freq", peak_freq, 1000);
        waitDone(2000, found);
        checkOutput("sweep_done_seen", found, 1);
        checkOutput("sweep_peak_freq", peak_freq, 1200);
        checkOutput("sweep_peak_mag", peak_mag, 50);
        checkOutput("sweep_ref_parked", ref_frequency, 1200);
        checkOutput("sweep_busy_clear", busy, 0);
        checkOutput("sweep_last_index", point_index, 4);
        @(posedge clk);
        #1;
        checkOutput("sweep_done_one_cycle", done, 0);

        // Invalid configurations.
        $display("[TB] invalid starts");
        applyStimulus(32'd1000, 32'd1400, 32'd0, 16'd4, 3'd2);
        checkOutput("zero_step_error", error, 1);
        checkOutput("zero_step_busy", busy, 0);
        @(posedge clk);
        #1;
        checkOutput("zero_step_error_pulse", error, 0);
        applyStimulus(32'd2000, 32'd1000, 32'd100, 16'd4, 3'd2);
        checkOutput("reversed_error", error, 1);
        checkOutput("reversed_busy", busy, 0);
        @(posedge clk);
        #1;
        checkOutput("reversed_error_pulse", error, 0);
        checkOutput("reversed_busy_later", busy, 0);
        checkOutput("peak_freq_held", peak_freq, 1200);
        checkOutput("peak_mag_held", peak_mag, 50);

        // Abort (with a coincident start) during averaging of point 2.
        $display("[TB] abort in point 2 averaging");
        applyStimulus(32'd1000, 32'd1400, 32'd100, 16'd4, 3'd2);
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (dut.state == ACCUM && point_index == 16'd2) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("abort_reached_point2", found, 1);
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        start = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_ref_hold", ref_frequency, 1200);
        checkOutput("abort_peak_freq", peak_freq, 1100);
        checkOutput("abort_peak_mag", peak_mag, 20);
        waitDone(200, found);
        checkOutput("abort_no_done", found, 0);
        checkOutput("abort_busy_later", busy, 0);

        // Frequency addition overflow ends the sweep after one point.
        $display("[TB] overflow sweep");
        applyStimulus(32'hFFFFFF00, 32'hFFFFFFFF, 32'h200, 16'd4, 3'd2);
        waitDone(2000, found);
        checkOutput("ovf_done_seen", found, 1);
        checkOutput("ovf_index", point_index, 0);
        checkOutput("ovf_peak_freq", peak_freq, 64'hFFFFFF00);
        checkOutput("ovf_peak_mag", peak_mag, 7);
        checkOutput("ovf_ref", ref_frequency, 64'hFFFFFF00);

        // Flat response, no settling, single sample per point; extra starts
        // with different settings arrive mid-sweep.
        $display("[TB] flat response sweep");
        flat_mag = 1'b1;
        applyStimulus(32'd1000, 32'd1400, 32'd100, 16'd0, 3'd0);
        for (int k = 0; k < 2; k++) begin
            repeat (3) @(posedge clk);
            #1;
            applyStimulus(32'd5000, 32'd9000, 32'd7, 16'd9, 3'd5);
            checkOutput("busy_start_ignored", busy, 1);
        end
        waitDone(2000, found);
        checkOutput("flat_done_seen", found, 1);
        checkOutput("flat_peak_freq", peak_freq, 1000);
        checkOutput("flat_peak_mag", peak_mag, 33);
        checkOutput("flat_index", point_index, 4);
        checkOutput("flat_ref", ref_frequency, 1000);
        flat_mag = 1'b0;

        // Reset in the middle of a sweep.
        $display("[TB] reset mid-sweep");
        applyStimulus(32'd1000, 32'd1400, 32'd100, 16'd4, 3'd2);
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_ref", ref_frequency, 0);
        checkOutput("midrst_peak_mag", peak_mag, 0);
        checkOutput("midrst_index", point_index, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        waitDone(200, found);
        checkOutput("midrst_no_done", found, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
